// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receive front-end: synchronizes the line, recovers frames at a fixed
// baud rate and hands bytes to a one-entry valid/ready holding register.
module uart_rx_deserializer #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int DIV      = CLK_FREQ / BAUD,
  parameter int HALF     = DIV / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_rx,
  output logic       io_deq_valid,
  input  logic       io_deq_ready,
  output logic [7:0] io_deq_bits,
  output logic       io_frame_err,
  output logic       io_overrun,
  output logic       io_busy
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q;
  logic          sync1_q;
  logic          rx_s_q;
  logic          rx_d_q;
  logic [2:0]    prime_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    bits_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic          busy_q;

  logic          fall_d;
  logic          accept_d;

  // prime_q keeps the reset values of the sync flops from looking like a real
  // high level, so a line that is already low after reset is not a start edge.
  always_comb begin
    fall_d   = prime_q[2] & rx_d_q & ~rx_s_q;
    accept_d = ~valid_q | io_deq_ready;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_d_q      <= 1'b1;
      prime_q     <= 3'b000;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      bits_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= io_rx;
      rx_s_q      <= sync1_q;
      rx_d_q      <= rx_s_q;
      prime_q     <= {prime_q[1:0], 1'b1};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // A plain handshake drains the holding register; a delivery below overrides it.
      if (valid_q && io_deq_ready) valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (fall_d) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_BIT) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_BIT) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (accept_d) begin
                bits_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              state_q     <= S_BREAK;
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign io_deq_valid = valid_q;
  assign io_deq_bits  = bits_q;
  assign io_frame_err = frame_err_q;
  assign io_overrun   = overrun_q;
  assign io_busy      = busy_q;

endmodule
